// File: rtl/cmp_pkg.sv
//------------------------------------------------------------------------------
// cmp_pkg : shared result codes and FSM states for the sliced comparator.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cmp_pkg;

  localparam logic [1:0] PD_LT = 2'd0;
  localparam logic [1:0] PD_EQ = 2'd1;
  localparam logic [1:0] PD_GT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/chunk_cmp.sv
//------------------------------------------------------------------------------
// chunk_cmp : combinational unsigned three-way compare of one CHUNK-bit slice.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module chunk_cmp
  import cmp_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic [1:0]       pd_o
);

  always_comb begin
    if (a_i < b_i)      pd_o = PD_LT;
    else if (a_i > b_i) pd_o = PD_GT;
    else                pd_o = PD_EQ;
  end

endmodule

`default_nettype wire

// File: rtl/cmp_seq.sv
//------------------------------------------------------------------------------
// cmp_seq : multi-cycle signed/unsigned three-way comparator, MS slice first.
// Optional macro CMP_EARLY_EXIT_EN stops the scan at the first differing slice.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cmp_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [1:0]       pd
);

  localparam int N = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(N - 1);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("cmp_seq: WIDTH must be a multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              sgn_q, sgn_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [1:0]        pd_q, pd_d;
`ifndef CMP_EARLY_EXIT_EN
  logic              found_q, found_d;
  logic [1:0]        first_q, first_d;
`endif

  logic [CHUNK-1:0]  a_sl, b_sl;
  logic [1:0]        slice_pd;

  // Signed order equals unsigned order once the sign bits are flipped.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
    if (sgn_q && (idx_q == IDX_TOP)) begin
      a_sl[CHUNK-1] = ~a_sl[CHUNK-1];
      b_sl[CHUNK-1] = ~b_sl[CHUNK-1];
    end
  end

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a_i  (a_sl),
    .b_i  (b_sl),
    .pd_o (slice_pd)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    pd_d    = pd_q;
`ifndef CMP_EARLY_EXIT_EN
    found_d = found_q;
    first_d = first_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = is_signed;
          idx_d   = IDX_TOP;
`ifndef CMP_EARLY_EXIT_EN
          found_d = 1'b0;
          first_d = PD_EQ;
`endif
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
`ifdef CMP_EARLY_EXIT_EN
        if (slice_pd != PD_EQ) begin
          pd_d    = slice_pd;
          state_d = DONE;
        end else if (idx_q == '0) begin
          pd_d    = PD_EQ;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`else
        // Keep only the most significant difference; later slices are ignored.
        if (!found_q && (slice_pd != PD_EQ)) begin
          found_d = 1'b1;
          first_d = slice_pd;
        end
        if (idx_q == '0) begin
          pd_d    = found_q ? first_q : slice_pd;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= IDX_TOP;
      pd_q    <= PD_EQ;
`ifndef CMP_EARLY_EXIT_EN
      found_q <= 1'b0;
      first_q <= PD_EQ;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      pd_q    <= pd_d;
`ifndef CMP_EARLY_EXIT_EN
      found_q <= found_d;
      first_q <= first_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign pd   = pd_q;

endmodule

`default_nettype wire

// File: tb/tb_cmp_seq.sv
//------------------------------------------------------------------------------
// tb_cmp_seq : directed scoreboard bench for cmp_seq (result and latency).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cmp_seq;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [1:0]       pd;

  cmp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .pd        (pd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] pd;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: full-width compare for pd, slice scan only for latency.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic s, input int now);
    exp_t e;
    int   lat;
    bit   hit;
    if (s) e.pd = ($signed(av) < $signed(bv)) ? 2'd0 : (av == bv) ? 2'd1 : 2'd2;
    else   e.pd = (av < bv) ? 2'd0 : (av == bv) ? 2'd1 : 2'd2;
    lat = N;
`ifdef CMP_EARLY_EXIT_EN
    hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!hit && (av[i*CHUNK +: CHUNK] != bv[i*CHUNK +: CHUNK])) begin
        hit = 1'b1;
        lat = N - i;
      end
    end
`else
    hit = 1'b0;
`endif
    e.due = now + lat + 1;
    return e;
  endfunction

  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic s);
    start     = 1'b1;
    a         = av;
    b         = bv;
    is_signed = s;
    sb.push_back(model(av, bv, s, cyc));
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    chk("wait_done", {31'd0, ok}, 1);
    chk("busy_in_done", {31'd0, busy}, 0);
  endtask

  task automatic single(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic s);
    @(negedge clk);
    issue(av, bv, s);
    @(negedge clk);
    start = 1'b0;
    chk("busy_in_run", {31'd0, busy}, 1);
    drain("drain_single");
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pd", {30'd0, pd}, {30'd0, e.pd});
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_pd", {30'd0, pd}, 1);
    reset = 1'b0;

    single(32'h0000_0005, 32'h0000_0003, 1'b0);
    single(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    single(32'h1234_5678, 32'h1234_5678, 1'b0);
    single(32'h1234_5678, 32'h1234_5678, 1'b1);
    single(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    single(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    single(32'h00AB_0000, 32'h00AC_FFFF, 1'b0);

    // Back-to-back: start held high, new operands loaded in each done cycle.
    @(negedge clk);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    wait_done();
    issue(32'h1234_5678, 32'h1234_5678, 1'b0);
    wait_done();
    issue(32'h0000_0005, 32'h0000_0003, 1'b0);
    @(negedge clk);
    start = 1'b0;
    drain("drain_b2b");

    // Start pulse during RUN must be dropped.
    @(negedge clk);
    issue(32'hCAFE_0001, 32'hCAFE_0001, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 32'h0000_0000; b = 32'hFFFF_FFFF; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    drain("drain_ignore");
    repeat (6) @(negedge clk);

    // Reset sampled on E2 of a RUN aborts it.
    @(negedge clk);
    issue(32'h1234_5678, 32'h1234_5678, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_pd", {30'd0, pd}, 1);
    sb.delete();
    reset = 1'b0;
    repeat (8) @(negedge clk);
    single(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
